sr_timer_bank: RTL and testbench

SR_TIMER_BANK -- requirements
Module: sr_timer_bank

---
 rtl/sr_timer_bank.sv | 102 ++++++++++
 tb/tb_sr_timer_bank.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_timer_bank.sv
// Bank of independent set/reset timers: one-shot, retriggerable, periodic and delay modes per channel.
// Latency: OUT/BUSY respond on the start edge; DONE is a registered pulse in the cycle after expiry.
// Backpressure: none; S is level-sampled every cycle and R overrides S on the same edge.
module sr_timer_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [CHANNELS-1:0]       S,
    input  logic [CHANNELS-1:0]       R,
    input  logic [CHANNELS*WIDTH-1:0] TIME,
    input  logic [2*CHANNELS-1:0]     MODE,
    output logic [CHANNELS-1:0]       OUT,
    output logic [CHANNELS-1:0]       DONE,
    output logic [CHANNELS-1:0]       BUSY
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] M_ONESHOT  = 2'b00;
    localparam logic [1:0] M_RETRIG   = 2'b01;
    localparam logic [1:0] M_PERIODIC = 2'b10;
    localparam logic [1:0] M_DELAY    = 2'b11;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] tlat;
        logic [1:0]       mlat;
        logic             out_q;
        logic             done_q;
        logic             busy_q;
        logic [WIDTH-1:0] t_in;
        logic [1:0]       m_in;
        logic             t_nz;
        logic             expire;

        assign t_in = TIME[i*WIDTH +: WIDTH];
        assign m_in = MODE[2*i +: 2];
        assign t_nz = (t_in != '0);
        // One extra bit so a full-scale TIME expires instead of wrapping.
        assign expire = (({1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1}) == {1'b0, tlat});

        assign OUT[i]  = out_q;
        assign DONE[i] = done_q;
        assign BUSY[i] = busy_q;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                state  <= IDLE;
                cnt    <= '0;
                tlat   <= '0;
                mlat   <= M_ONESHOT;
                out_q  <= 1'b0;
                done_q <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (R[i]) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    out_q  <= 1'b0;
                    busy_q <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            // A held DELAY output blocks new starts until cleared.
                            if (S[i] && t_nz && !out_q) begin
                                state  <= RUN;
                                cnt    <= '0;
                                tlat   <= t_in;
                                mlat   <= m_in;
                                out_q  <= (m_in != M_DELAY);
                                busy_q <= 1'b1;
                            end
                        end
                        RUN: begin
                            if (mlat == M_RETRIG && S[i] && t_nz) begin
                                cnt  <= '0;
                                tlat <= t_in;
                            end else if (expire) begin
                                done_q <= 1'b1;
                                cnt    <= '0;
                                if (mlat != M_PERIODIC) begin
                                    state  <= IDLE;
                                    busy_q <= 1'b0;
                                    out_q  <= (mlat == M_DELAY);
                                end
                            end else begin
                                cnt <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_sr_timer_bank.sv
// Directed bench for sr_timer_bank: countdown-style reference model checked every cycle,
// plus literal pulse-width and pulse-count expectations for each mode and boundary.
module tb_sr_timer_bank;
    localparam int CH = 4;
    localparam int W  = 8;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [CH-1:0]   S;
    logic [CH-1:0]   R;
    logic [CH*W-1:0] TIME;
    logic [2*CH-1:0] MODE;
    logic [CH-1:0]   OUT;
    logic [CH-1:0]   DONE;
    logic [CH-1:0]   BUSY;

    int total = 0;
    int bad   = 0;
    int out_hi [CH];
    int done_n [CH];

    // Reference model: remaining cycles until expiry, counted down.
    bit m_run  [CH];
    bit m_out  [CH];
    bit m_done [CH];
    int m_rem  [CH];
    int m_tl   [CH];
    int m_md   [CH];

    always #5 CLK = ~CLK;

    sr_timer_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .S    (S),
        .R    (R),
        .TIME (TIME),
        .MODE (MODE),
        .OUT  (OUT),
        .DONE (DONE),
        .BUSY (BUSY)
    );

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < CH; i++) begin
                m_run[i] = 0; m_out[i] = 0; m_done[i] = 0;
                m_rem[i] = 0; m_tl[i] = 0;  m_md[i] = 0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                int t;
                int md;
                t  = int'(TIME[i*W +: W]);
                md = int'(MODE[2*i +: 2]);
                m_done[i] = 0;
                if (R[i]) begin
                    m_run[i] = 0;
                    m_out[i] = 0;
                end else if (!m_run[i]) begin
                    if (S[i] && t > 0 && !m_out[i]) begin
                        m_run[i] = 1;
                        m_rem[i] = t;
                        m_tl[i]  = t;
                        m_md[i]  = md;
                        m_out[i] = (md != 3);
                    end
                end else if (m_md[i] == 1 && S[i] && t > 0) begin
                    m_rem[i] = t;
                    m_tl[i]  = t;
                end else begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_done[i] = 1;
                        if (m_md[i] == 2) begin
                            m_rem[i] = m_tl[i];
                        end else begin
                            m_run[i] = 0;
                            m_out[i] = (m_md[i] == 3);
                        end
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("out[%0d]", i),  int'(OUT[i]),  int'(m_out[i]));
            chk($sformatf("done[%0d]", i), int'(DONE[i]), int'(m_done[i]));
            chk($sformatf("busy[%0d]", i), int'(BUSY[i]), int'(m_run[i]));
            if (OUT[i])  out_hi[i]++;
            if (DONE[i]) done_n[i]++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic cfg(input int ch, input int t, input int md);
        TIME[ch*W +: W] = t[W-1:0];
        MODE[2*ch +: 2] = md[1:0];
    endtask

    task automatic clr();
        for (int i = 0; i < CH; i++) begin
            out_hi[i] = 0;
            done_n[i] = 0;
        end
    endtask

    initial begin
        RST_N = 1'b0;
        S = '0; R = '0; TIME = '0; MODE = '0;
        clr();
        #3;
        chk("reset_out",  int'(OUT),  0);
        chk("reset_done", int'(DONE), 0);
        chk("reset_busy", int'(BUSY), 0);

        // Start request while reset is still asserted must be dropped
        tick(2);
        cfg(0, 5, 0);
        S[0] = 1'b1;
        tick(1);
        chk("start_in_reset_busy", int'(BUSY[0]), 0);
        S[0] = 1'b0;
        RST_N = 1'b1;
        tick(2);

        // ONESHOT T=5, TIME/MODE changed mid-run
        cfg(0, 5, 0);
        S[0] = 1'b1;
        clr();
        tick(1);
        S[0] = 1'b0;
        cfg(0, 9, 2);
        tick(7);
        chk("oneshot_out_cycles", out_hi[0], 5);
        chk("oneshot_done_count", done_n[0], 1);

        // RETRIG T=4, S at cycles 0 and 3
        cfg(1, 4, 1);
        S[1] = 1'b1;
        clr();
        tick(1);
        S[1] = 1'b0;
        tick(2);
        S[1] = 1'b1;
        tick(1);
        S[1] = 1'b0;
        tick(8);
        chk("retrig_out_cycles", out_hi[1], 7);
        chk("retrig_done_count", done_n[1], 1);

        // PERIODIC T=3 for four periods, then R mid-period
        cfg(2, 3, 2);
        S[2] = 1'b1;
        clr();
        tick(1);
        S[2] = 1'b0;
        cfg(2, 7, 0);
        tick(12);
        chk("periodic_done_count", done_n[2], 4);
        chk("periodic_out_cycles", out_hi[2], 13);
        R[2] = 1'b1;
        tick(1);
        R[2] = 1'b0;
        clr();
        tick(6);
        chk("periodic_after_r_out",  out_hi[2], 0);
        chk("periodic_after_r_done", done_n[2], 0);

        // DELAY T=6, S ignored once output is high, R clears
        cfg(3, 6, 3);
        S[3] = 1'b1;
        clr();
        tick(1);
        S[3] = 1'b0;
        tick(5);
        chk("delay_low_out",  out_hi[3], 0);
        chk("delay_low_done", done_n[3], 0);
        S[3] = 1'b1;
        tick(4);
        chk("delay_high_out",  out_hi[3], 4);
        chk("delay_high_done", done_n[3], 1);
        S[3] = 1'b0;
        R[3] = 1'b1;
        tick(1);
        R[3] = 1'b0;
        tick(1);
        chk("delay_cleared", int'(OUT[3]), 0);

        // TIME=0 start ignored
        cfg(0, 0, 0);
        S[0] = 1'b1;
        clr();
        tick(1);
        S[0] = 1'b0;
        tick(2);
        chk("time0_out",  out_hi[0], 0);
        chk("time0_busy", int'(BUSY[0]), 0);

        // S and R on the same edge
        cfg(1, 4, 0);
        S[1] = 1'b1;
        R[1] = 1'b1;
        clr();
        tick(1);
        S[1] = 1'b0;
        R[1] = 1'b0;
        tick(3);
        chk("s_and_r_out", out_hi[1], 0);

        // Full-scale TIME one-shot
        cfg(0, 255, 0);
        S[0] = 1'b1;
        clr();
        tick(1);
        S[0] = 1'b0;
        tick(258);
        chk("maxtime_out_cycles", out_hi[0], 255);
        chk("maxtime_done_count", done_n[0], 1);

        // Independent channels, R on one only, then async reset mid-run
        cfg(0, 20, 0);
        cfg(1, 3, 2);
        cfg(2, 10, 1);
        S = 4'b0111;
        tick(1);
        S = '0;
        tick(4);
        R[2] = 1'b1;
        tick(1);
        R[2] = 1'b0;
        tick(2);
        chk("indep_ch0_running", int'(OUT[0]), 1);
        chk("indep_ch2_cleared", int'(OUT[2]), 0);
        clr();
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_out",  int'(OUT),  0);
        chk("async_rst_done", int'(DONE), 0);
        chk("async_rst_busy", int'(BUSY), 0);
        tick(2);
        RST_N = 1'b1;
        tick(3);
        chk("async_rst_no_done0", done_n[0], 0);
        chk("async_rst_no_done1", done_n[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
